// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared types and encodings for the multi-cycle main controller
// Optional build macro in the top: MULTICYCLE_CTRL_PERF_CNT_EN.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd12,
    S_HALT     = 4'd13,
    S_ERROR    = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       zero_ext;
    logic       illegal;
    logic       bus_err;
    logic       halted;
  } ctrl_t;

  function automatic state_e dispatch(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:              return S_MEM_ADDR;
      OP_RTYPE:                  return S_R_EXEC;
      OP_ADDI, OP_SLTI, OP_ORI:  return S_I_EXEC;
      OP_BEQ, OP_BNE:            return S_BRANCH;
      OP_J:                      return S_JUMP;
      default:                   return S_ILLEGAL;
    endcase
  endfunction

  // States that stall on the unified memory and feed the wait timer.
  function automatic logic is_mem_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - counts consecutive memory wait cycles and flags a timeout
// WAIT_LIMIT=0 disables the timeout.
module mc_wait_timer #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wait_i,
  output logic timeout_o
);

  localparam int CW = (WAIT_LIMIT <= 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [CW-1:0] LAST = CW'((WAIT_LIMIT > 0) ? (WAIT_LIMIT - 1) : 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (wait_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the wait cycle that brings the run length up to WAIT_LIMIT.
  assign timeout_o = (WAIT_LIMIT > 0) && wait_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM sequencing a multi-cycle MIPS-subset datapath
// Optional build macro: MULTICYCLE_CTRL_PERF_CNT_EN (cycle and retired-instruction counters).
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  input  logic             halt_req_i,
  output logic             pc_en_o,
  output logic [1:0]       pc_src_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             zero_ext_o,
  output logic             illegal_o,
  output logic             bus_err_o,
  output logic             halted_o
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
`endif
);

  state_e state_q;
  state_e state_d;
  state_e boundary;
  ctrl_t  ctrl;
  logic   mem_wait;
  logic   timeout;

  assign mem_wait = is_mem_wait_state(state_q) && !mem_ready_i;
  assign boundary = halt_req_i ? S_HALT : S_FETCH;

  mc_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wait_i    (mem_wait),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (timeout)          state_d = S_ERROR;
        else if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE:   state_d = dispatch(opcode_i);
      S_MEM_ADDR: state_d = (opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (timeout)          state_d = S_ERROR;
        else if (mem_ready_i) state_d = S_MEM_WB;
      end
      S_MEM_WR: begin
        if (timeout)          state_d = S_ERROR;
        else if (mem_ready_i) state_d = boundary;
      end
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_ILLEGAL: state_d = boundary;
      S_HALT: begin
        if (!halt_req_i)      state_d = S_FETCH;
      end
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_FETCH;
    endcase
  end

  // Held reset masks every output, since the state register already sits in FETCH.
  always_comb begin
    ctrl = '0;
    if (rst_i) begin
      case (state_q)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALU_ADD;
          ctrl.pc_src    = PCSRC_ALU;
          if (mem_ready_i) begin
            ctrl.ir_write = 1'b1;
            ctrl.pc_en    = 1'b1;
          end
        end
        S_DECODE: begin
          ctrl.alu_src_b = SRCB_IMM_SH;
          ctrl.alu_op    = ALU_ADD;
        end
        S_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALU_ADD;
        end
        S_MEM_RD: begin
          ctrl.iord     = 1'b1;
          ctrl.mem_read = 1'b1;
        end
        S_MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          ctrl.iord      = 1'b1;
          ctrl.mem_write = 1'b1;
        end
        S_R_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_B;
          ctrl.alu_op    = ALU_FUNCT;
        end
        S_R_WB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
        S_I_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          case (opcode_i)
            OP_SLTI: ctrl.alu_op = ALU_SLT;
            OP_ORI: begin
              ctrl.alu_op   = ALU_OR;
              ctrl.zero_ext = 1'b1;
            end
            default: ctrl.alu_op = ALU_ADD;
          endcase
        end
        S_I_WB: begin
          ctrl.reg_write = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_B;
          ctrl.alu_op    = ALU_SUB;
          ctrl.pc_src    = PCSRC_ALUOUT;
          ctrl.pc_en     = zero_i ^ (opcode_i == OP_BNE);
        end
        S_JUMP: begin
          ctrl.pc_src = PCSRC_JUMP;
          ctrl.pc_en  = 1'b1;
        end
        S_ILLEGAL: ctrl.illegal = 1'b1;
        S_HALT:    ctrl.halted  = 1'b1;
        S_ERROR:   ctrl.bus_err = 1'b1;
        default:   ctrl = '0;
      endcase
    end
  end

  assign pc_en_o      = ctrl.pc_en;
  assign pc_src_o     = ctrl.pc_src;
  assign iord_o       = ctrl.iord;
  assign mem_read_o   = ctrl.mem_read;
  assign mem_write_o  = ctrl.mem_write;
  assign ir_write_o   = ctrl.ir_write;
  assign reg_write_o  = ctrl.reg_write;
  assign reg_dst_o    = ctrl.reg_dst;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign alu_op_o     = ctrl.alu_op;
  assign zero_ext_o   = ctrl.zero_ext;
  assign illegal_o    = ctrl.illegal;
  assign bus_err_o    = ctrl.bus_err;
  assign halted_o     = ctrl.halted;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] instr_cnt_q;
  logic             retire;
  logic             frozen;

  assign retire = (state_q == S_MEM_WB) || (state_q == S_R_WB) || (state_q == S_I_WB) ||
                  (state_q == S_BRANCH) || (state_q == S_JUMP) || (state_q == S_ILLEGAL) ||
                  ((state_q == S_MEM_WR) && mem_ready_i);
  assign frozen = (state_q == S_HALT) || (state_q == S_ERROR);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else if (!frozen) begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (retire) begin
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instr_cnt_o = instr_cnt_q;
`endif

endmodule
